// File: rtl/lc3_pipeline_stage3_mem_if.sv
// Memory port between the LC-3 memory-access stage (master) and its memory (slave).
interface lc3_pipeline_stage3_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/lc3_pipeline_stage3_mem.sv
// LC-3 memory-access stage: direct/indirect loads and stores over a req/ready port.
// Optional access timeout enabled by defining LC3_MEM_TIMEOUT_EN.
module lc3_pipeline_stage3_mem #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        I_valid,
    input  logic [19:0] I_DR,
    input  logic [1:0]  I_WBtype,
    input  logic [2:0]  I_Memtype,
    input  logic [15:0] I_aluout,
    output logic [19:0] O_DR,
    output logic [1:0]  O_WBtype,
    output logic        O_valid,
    output logic        mem_stall,
    output logic [19:0] dr3,
    output logic        mem_err,
    lc3_pipeline_stage3_mem_if.master mem
);
    typedef enum logic [1:0] {IDLE, ACC, IND, DONE} state_t;
    typedef struct packed {
        logic ld;
        logic st;
        logic ind;
    } op_t;

    state_t      state, state_nxt;
    op_t         op_q, op_in;
    logic [19:0] dr_q;
    logic [1:0]  wb_q;
    logic [15:0] addr_q, wdata_q;
    logic        vld_q, gap_q, err_q;
    logic        accept, req, hit, abort;

    always_comb begin
        op_in = '0;
        case (I_Memtype)
            3'b001:  op_in.ld = 1'b1;
            3'b010:  op_in.st = 1'b1;
            3'b101:  begin op_in.ld = 1'b1; op_in.ind = 1'b1; end
            3'b110:  begin op_in.st = 1'b1; op_in.ind = 1'b1; end
            default: ;
        endcase
    end

    assign accept = !stall && (state == IDLE || state == DONE);
    // gap_q holds the request low for one cycle between the two halves of an indirect op
    assign req    = (state == ACC) || (state == IND && !gap_q);
    assign hit    = req && mem.mem_ready;

`ifdef LC3_MEM_TIMEOUT_EN
    logic [7:0] wait_cnt;
    assign abort = req && !mem.mem_ready && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(negedge clk or negedge reset) begin
        if (!reset)              wait_cnt <= '0;
        else if (accept || hit)  wait_cnt <= '0;
        else if (req)            wait_cnt <= wait_cnt + 8'd1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign abort = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        mem.mem_req  = req;
        mem.mem_we   = 1'b0;
        mem_stall    = 1'b0;
        O_valid      = 1'b0;
        case (state)
            IDLE: begin
                O_valid = vld_q;
                if (accept) state_nxt = (I_valid && (op_in.ld || op_in.st)) ? ACC : IDLE;
            end
            ACC: begin
                mem_stall  = 1'b1;
                mem.mem_we = op_q.st && !op_q.ind;
                if (hit)        state_nxt = op_q.ind ? IND : DONE;
                else if (abort) state_nxt = DONE;
            end
            IND: begin
                mem_stall  = 1'b1;
                mem.mem_we = req && op_q.st;
                if (hit || abort) state_nxt = DONE;
            end
            DONE: begin
                O_valid = 1'b1;
                if (accept) state_nxt = (I_valid && (op_in.ld || op_in.st)) ? ACC : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            op_q    <= '0;
            dr_q    <= '0;
            wb_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            vld_q   <= 1'b0;
            gap_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            gap_q <= 1'b0;
            if (accept) begin
                op_q    <= op_in;
                dr_q    <= {I_DR[19] & ~op_in.st, I_DR[18:0]};
                wb_q    <= I_WBtype;
                addr_q  <= I_aluout;
                wdata_q <= I_DR[15:0];
                vld_q   <= I_valid;
                err_q   <= 1'b0;
            end else if (hit) begin
                // first half of an indirect op returns the pointer for the second half
                if (state == ACC && op_q.ind) begin
                    addr_q <= mem.mem_rdata;
                    gap_q  <= 1'b1;
                end else if (op_q.ld) begin
                    dr_q[15:0] <= mem.mem_rdata;
                end
            end else if (abort) begin
                dr_q[19] <= 1'b0;
                err_q    <= 1'b1;
            end
        end
    end

    assign O_DR          = dr_q;
    assign O_WBtype      = wb_q;
    assign dr3           = {dr_q[19] & ~mem_stall, dr_q[18:0]};
    assign mem_err       = err_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
endmodule

// File: tb/tb_lc3_pipeline_stage3_mem.sv
// Bench for lc3_pipeline_stage3_mem: directed cases plus randomized ops against a
// transaction-level model (expected result, memory accesses and latency per op).
module tb_lc3_pipeline_stage3_mem;
    logic        clk, reset, stall, I_valid;
    logic [19:0] I_DR;
    logic [1:0]  I_WBtype;
    logic [2:0]  I_Memtype;
    logic [15:0] I_aluout;
    logic [19:0] O_DR, dr3;
    logic [1:0]  O_WBtype;
    logic        O_valid, mem_stall, mem_err;

    lc3_pipeline_stage3_mem_if mif();

    lc3_pipeline_stage3_mem #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .stall(stall), .I_valid(I_valid), .I_DR(I_DR),
        .I_WBtype(I_WBtype), .I_Memtype(I_Memtype), .I_aluout(I_aluout),
        .O_DR(O_DR), .O_WBtype(O_WBtype), .O_valid(O_valid), .mem_stall(mem_stall),
        .dr3(dr3), .mem_err(mem_err), .mem(mif)
    );

    int tests, fails;
    logic [15:0] mem [0:65535];
    int cur_waits, rcnt;
    logic [15:0] acc_addr[$];
    logic        acc_we[$];
    logic [15:0] acc_wdata[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory slave: answers a request after cur_waits idle cycles, logs every completed access.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mif.mem_ready = 1'b0;
            mif.mem_rdata = 16'h0;
            rcnt = 0;
        end else if (mif.mem_ready) begin
            mif.mem_ready = 1'b0;
            rcnt = 0;
        end else if (mif.mem_req) begin
            if (rcnt >= cur_waits) begin
                mif.mem_ready = 1'b1;
                mif.mem_rdata = mem[mif.mem_addr];
                if (mif.mem_we) mem[mif.mem_addr] = mif.mem_wdata;
                acc_addr.push_back(mif.mem_addr);
                acc_we.push_back(mif.mem_we);
                acc_wdata.push_back(mif.mem_wdata);
                rcnt = 0;
            end else begin
                rcnt++;
            end
        end else begin
            rcnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bubble();
        I_valid = 1'b0; I_Memtype = 3'b000;
    endtask

    task automatic clear_log();
        acc_addr.delete(); acc_we.delete(); acc_wdata.delete();
    endtask

    // One instruction through the stage; expectations come from the opcode rules alone.
    task automatic run_op(input logic [2:0] mt, input logic [19:0] dr, input logic [15:0] alu,
                          input logic [1:0] wb, input logic v, input int w);
        logic        is_ld, is_st, is_ind, is_mem;
        logic [19:0] exp_dr;
        logic [15:0] ptr, a, d;
        logic        we;
        logic [15:0] ea[$];
        logic        ewe[$];
        logic [15:0] ewd[$];
        int          exp_lat;
        is_ld  = (mt == 3'b001) || (mt == 3'b101);
        is_st  = (mt == 3'b010) || (mt == 3'b110);
        is_ind = (mt == 3'b101) || (mt == 3'b110);
        is_mem = v && (is_ld || is_st);
        exp_dr = dr;
        if (is_st) exp_dr[19] = 1'b0;
        if (is_mem && !is_ind) begin
            ea.push_back(alu); ewe.push_back(is_st); ewd.push_back(dr[15:0]);
            if (is_ld) exp_dr[15:0] = mem[alu];
        end else if (is_mem) begin
            ptr = mem[alu];
            ea.push_back(alu); ewe.push_back(1'b0); ewd.push_back(16'h0);
            ea.push_back(ptr); ewe.push_back(is_st); ewd.push_back(dr[15:0]);
            if (is_ld) exp_dr[15:0] = mem[ptr];
        end
        // accept cycle, then (1 + waits) per access, plus one idle request cycle between accesses
        exp_lat = !is_mem ? 1 : is_ind ? 1 + 2 * (w + 1) + 1 : 1 + (w + 1);

        @(posedge clk); #1;
        I_valid = v; I_Memtype = mt; I_DR = dr; I_aluout = alu; I_WBtype = wb; cur_waits = w;
        @(negedge clk); #1;
        bubble();
        for (int c = 1; c <= exp_lat; c++) begin
            @(posedge clk); #1;
            if (c < exp_lat) begin
                chk("busy_valid", O_valid, 0);
                chk("busy_stall", mem_stall, 1);
                chk("busy_dr3_we", dr3[19], 0);
            end else begin
                chk("done_valid", O_valid, v);
                chk("done_stall", mem_stall, 0);
                chk("done_req", mif.mem_req, 0);
                chk("done_err", mem_err, 0);
                if (v) begin
                    chk("done_odr", O_DR, exp_dr);
                    chk("done_dr3", dr3, exp_dr);
                    chk("done_wb", O_WBtype, wb);
                end
            end
        end
        chk("acc_count", acc_addr.size(), ea.size());
        while (acc_addr.size() > 0 && ea.size() > 0) begin
            a = acc_addr.pop_front(); we = acc_we.pop_front(); d = acc_wdata.pop_front();
            chk("acc_addr", a, ea.pop_front());
            chk("acc_we", we, ewe[0]);
            if (ewe.pop_front()) chk("acc_wdata", d, ewd[0]);
            void'(ewd.pop_front());
        end
        clear_log();
    endtask

    initial begin
        tests = 0; fails = 0; cur_waits = 0;
        reset = 1'b0; stall = 1'b0; I_DR = 20'h0; I_WBtype = 2'b00; I_aluout = 16'h0;
        bubble();
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);

        #2;
        chk("rst_odr", O_DR, 0);
        chk("rst_valid", O_valid, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_dr3", dr3, 0);
        chk("rst_req", mif.mem_req, 0);
        chk("rst_we", mif.mem_we, 0);
        chk("rst_addr", mif.mem_addr, 0);
        chk("rst_err", mem_err, 0);
        chk("rst_wb", O_WBtype, 0);
        @(posedge clk); #1 reset = 1'b1;

        run_op(3'b000, 20'h91234, 16'h0000, 2'b01, 1'b1, 0);
        mem[16'h3000] = 16'hBEEF;
        run_op(3'b001, 20'h80000, 16'h3000, 2'b10, 1'b1, 2);
        mem[16'h4000] = 16'h5000;
        run_op(3'b110, 20'h900AA, 16'h4000, 2'b00, 1'b1, 1);
        chk("st_ind_mem", mem[16'h5000], 16'h00AA);
        mem[16'hFFFF] = 16'h0000; mem[16'h0000] = 16'h1357;
        run_op(3'b101, 20'hA0000, 16'hFFFF, 2'b11, 1'b1, 0);
        run_op(3'b010, 20'hF1234, 16'hFFFF, 2'b01, 1'b1, 0);
        chk("st_mem", mem[16'hFFFF], 16'h1234);
        run_op(3'b001, 20'h8FFFF, 16'h0010, 2'b01, 1'b0, 0);

        // stall while the access is in flight: result parks and holds
        mem[16'h2222] = 16'h7777;
        @(posedge clk); #1;
        I_valid = 1'b1; I_Memtype = 3'b001; I_DR = 20'hB0000; I_aluout = 16'h2222; I_WBtype = 2'b10;
        cur_waits = 1;
        @(negedge clk); #1;
        stall = 1'b1; bubble();
        repeat (2) begin
            @(posedge clk); #1;
            chk("stl_busy", mem_stall, 1);
        end
        repeat (3) begin
            @(posedge clk); #1;
            chk("stl_valid", O_valid, 1);
            chk("stl_odr", O_DR, 20'hB7777);
        end
        stall = 1'b0; I_valid = 1'b1; I_Memtype = 3'b000; I_DR = 20'h54321; I_WBtype = 2'b01;
        @(negedge clk); #1;
        bubble();
        @(posedge clk); #1;
        chk("stl_next_odr", O_DR, 20'h54321);
        chk("stl_next_valid", O_valid, 1);
        chk("stl_acc", acc_addr.size(), 1);
        clear_log();

        // reset in the middle of an access
        @(posedge clk); #1;
        I_valid = 1'b1; I_Memtype = 3'b001; I_DR = 20'hC1111; I_aluout = 16'h0ABC; cur_waits = 1000;
        @(negedge clk); #1;
        bubble();
        repeat (2) @(posedge clk);
        #1 chk("mid_req", mif.mem_req, 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_req", mif.mem_req, 0);
        chk("mid_rst_valid", O_valid, 0);
        chk("mid_rst_stall", mem_stall, 0);
        chk("mid_rst_odr", O_DR, 0);
        @(posedge clk); #1 reset = 1'b1;
        cur_waits = 0;
        chk("mid_rst_acc", acc_addr.size(), 0);
        clear_log();
        run_op(3'b000, 20'h30F0F, 16'h0000, 2'b10, 1'b1, 0);

`ifdef LC3_MEM_TIMEOUT_EN
        @(posedge clk); #1;
        I_valid = 1'b1; I_Memtype = 3'b001; I_DR = 20'hC0000; I_aluout = 16'h1111; cur_waits = 1000;
        @(negedge clk); #1;
        bubble();
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (c < 5) begin
                chk("to_req", mif.mem_req, 1);
            end else begin
                chk("to_req_drop", mif.mem_req, 0);
                chk("to_err", mem_err, 1);
                chk("to_valid", O_valid, 1);
                chk("to_dr_we", O_DR[19], 0);
            end
        end
        cur_waits = 0;
        clear_log();
        run_op(3'b000, 20'h12345, 16'h0000, 2'b00, 1'b1, 0);
`endif

        for (int i = 0; i < 40; i++)
            run_op(3'($urandom_range(0, 7)), 20'($urandom), 16'($urandom), 2'($urandom),
                   1'($urandom_range(0, 3) != 0), $urandom_range(0, 2));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
